// File: rtl/alu_operand_stage.sv
// Operand-issue stage: 2^AW x WIDTH register file, operand select and a main+skid output buffer.
// Define ALU_OPSTAGE_BYPASS_EN to forward same-cycle writeback data into captured operands.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [2:0]       cmd_in,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] operandA,
  output logic [WIDTH-1:0] operandB,
  output logic [2:0]       command
);

  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] regs_q [Depth];
  logic [WIDTH-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
  logic [2:0]       main_cmd_q, skid_cmd_q;

  logic             accept, consume;
  logic [WIDTH-1:0] rd_a, rd_b, new_b;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid && in_ready_q;
  assign consume   = out_valid && out_ready;
  assign operandA  = main_a_q;
  assign operandB  = main_b_q;
  assign command   = main_cmd_q;

  always_comb begin
    rd_a = (rs == '0) ? '0 : regs_q[rs];
    rd_b = (rt == '0) ? '0 : regs_q[rt];
`ifdef ALU_OPSTAGE_BYPASS_EN
    if (wb_en && (rs != '0) && (wb_addr == rs)) rd_a = wb_data;
    if (wb_en && (rt != '0) && (wb_addr == rt)) rd_b = wb_data;
`endif
    new_b = use_imm ? imm : rd_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != '0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      main_a_q   <= '0;
      main_b_q   <= '0;
      main_cmd_q <= '0;
      skid_a_q   <= '0;
      skid_b_q   <= '0;
      skid_cmd_q <= '0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            main_a_q   <= rd_a;
            main_b_q   <= new_b;
            main_cmd_q <= cmd_in;
            state_q    <= StOne;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_a_q   <= rd_a;
            main_b_q   <= new_b;
            main_cmd_q <= cmd_in;
          end else if (accept) begin
            // ALU stalled: park the new op behind main and stop accepting.
            skid_a_q   <= rd_a;
            skid_b_q   <= new_b;
            skid_cmd_q <= cmd_in;
            state_q    <= StTwo;
            in_ready_q <= 1'b0;
          end else if (consume) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (consume) begin
            main_a_q   <= skid_a_q;
            main_b_q   <= skid_b_q;
            main_cmd_q <= skid_cmd_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= StEmpty;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a queue/array reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, use_imm, wb_en, out_valid, out_ready;
  logic [4:0]  rs, rt, wb_addr;
  logic [31:0] imm, wb_data, operandA, operandB;
  logic [2:0]  cmd_in, command;

  always #5 clk = ~clk;

  alu_operand_stage #(.WIDTH(32), .AW(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs        (rs),
    .rt        (rt),
    .imm       (imm),
    .use_imm   (use_imm),
    .cmd_in    (cmd_in),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .operandA  (operandA),
    .operandB  (operandB),
    .command   (command)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } op_t;

  op_t         q[$];
  logic [31:0] mregs[32];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

`ifdef ALU_OPSTAGE_BYPASS_EN
  localparam logic [31:0] BypassExp = 32'hAAAA_5555;
`else
  localparam logic [31:0] BypassExp = 32'h0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("model_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    chk("model_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
    if (q.size() > 0) begin
      chk("model_operandA", operandA, q[0].a);
      chk("model_operandB", operandB, q[0].b);
      chk("model_command", {29'b0, command}, {29'b0, q[0].c});
    end
  endtask

  // One clock cycle: drive inputs, compare against model, advance model at the edge.
  task automatic step(input logic iv, input logic [4:0] a_rs, input logic [4:0] a_rt,
                      input logic [31:0] a_imm, input logic a_ui, input logic [2:0] a_cmd,
                      input logic a_wbe, input logic [4:0] a_wba, input logic [31:0] a_wbd,
                      input logic ordy);
    op_t         n;
    logic        acc, con;
    logic [31:0] va, vb;
    in_valid = iv; rs = a_rs; rt = a_rt; imm = a_imm; use_imm = a_ui; cmd_in = a_cmd;
    wb_en = a_wbe; wb_addr = a_wba; wb_data = a_wbd; out_ready = ordy;
    check_outputs();
    acc = iv && (q.size() < 2);
    con = (q.size() > 0) && ordy;
    va = (a_rs == 5'd0) ? 32'h0 : mregs[a_rs];
    vb = (a_rt == 5'd0) ? 32'h0 : mregs[a_rt];
`ifdef ALU_OPSTAGE_BYPASS_EN
    if (a_wbe && a_rs != 5'd0 && a_wba == a_rs) va = a_wbd;
    if (a_wbe && a_rt != 5'd0 && a_wba == a_rt) vb = a_wbd;
`endif
    n.a = va;
    n.b = a_ui ? a_imm : vb;
    n.c = a_cmd;
    @(posedge clk);
    if (con) void'(q.pop_front());
    if (acc) q.push_back(n);
    if (a_wbe && a_wba != 5'd0) mregs[a_wba] = a_wbd;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    q.delete();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_operandA", operandA, 32'h0);
    chk("rst_operandB", operandB, 32'h0);
    chk("rst_command", {29'b0, command}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rs = '0; rt = '0; imm = '0; use_imm = 1'b0; cmd_in = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b0;
    do_reset();

    // Register operands, SUB.
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b1, 5'd5, 32'h10, 1'b1);
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b1, 5'd6, 32'h3, 1'b1);
    step(1'b1, 5'd5, 5'd6, 32'h0, 1'b0, 3'd1, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("sub_valid", {31'b0, out_valid}, 32'h1);
    chk("sub_opA", operandA, 32'h10);
    chk("sub_opB", operandB, 32'h3);
    chk("sub_cmd", {29'b0, command}, 32'h1);
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    // R0 write ignored, immediate operand.
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b1, 5'd0, 32'h1234, 1'b1);
    step(1'b1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 3'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("r0_opA", operandA, 32'h0);
    chk("imm_opB", operandB, 32'hFFFF_FFFF);
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    // Back-pressure: A then B, then drain in order.
    step(1'b1, 5'd5, 5'd6, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd6, 5'd5, 32'h0, 1'b0, 3'd2, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
    chk("bp_first_A", operandA, 32'h10);
    step(1'b1, 5'd1, 5'd1, 32'h0, 1'b0, 3'd4, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("bp_in_ready_back", {31'b0, in_ready}, 32'h1);
    chk("bp_second_B", operandA, 32'h3);
    chk("bp_second_cmd", {29'b0, command}, 32'h2);
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("bp_drained", {31'b0, out_valid}, 32'h0);

    // Same-cycle writeback and read of R7.
    step(1'b1, 5'd7, 5'd0, 32'h0, 1'b0, 3'd0, 1'b1, 5'd7, 32'hAAAA_5555, 1'b0);
    chk("bypass_opA", operandA, BypassExp);
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    // Fill both slots, reset, then every register reads zero.
    step(1'b1, 5'd5, 5'd6, 32'h0, 1'b0, 3'd3, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd7, 5'd6, 32'h0, 1'b0, 3'd5, 1'b0, 5'd0, 32'h0, 1'b0);
    do_reset();
    for (int i = 0; i < 32; i++)
      step(1'b1, 5'(i), 5'(31 - i), 32'h0, 1'b0, 3'd6, 1'b0, 5'd0, 32'h0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b1);

    // Seed registers, then an 8-op stream at full rate.
    for (int i = 1; i < 32; i++)
      step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b1, 5'(i), $urandom, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'($urandom), 5'($urandom), $urandom, 1'($urandom), 3'($urandom),
           1'b0, 5'd0, 32'h0, 1'b1);
      chk("stream_in_ready", {31'b0, in_ready}, 32'h1);
      chk("stream_out_valid", {31'b0, out_valid}, 32'h1);
    end

    // Random traffic, with writebacks aimed at the read ports some of the time.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r_rs, r_rt, r_wa;
      r_rs = 5'($urandom_range(0, 7));
      r_rt = 5'($urandom_range(0, 7));
      r_wa = ($urandom_range(0, 3) == 0) ? r_rs : 5'($urandom_range(0, 7));
      step(1'($urandom), r_rs, r_rt, $urandom, ($urandom_range(0, 3) == 0), 3'($urandom),
           1'($urandom), r_wa, $urandom, ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 5'd0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("final_empty", {31'b0, out_valid}, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
